// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin arbiter for two 32-bit word requesters that sends the
//            granted word as four 8N1 UART bytes, most significant byte first.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [31:0] data0,
    input  logic        req1,
    input  logic [31:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic        TxD,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] C_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q,    state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q,     word_d;
    logic        prio_q,     prio_d;
    logic        txd_q,      txd_d;
    logic        busy_q,     busy_d;
    logic        ack0_q,     ack0_d;
    logic        ack1_q,     ack1_d;
    logic        done_q,     done_d;

    logic [7:0]  w_cur_byte;
    logic [2:0]  w_next_bit;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_bit_end;

    // prio_q == 0 favours requester 0; it flips to the loser after every grant.
    assign w_grant0   = req0 & (~prio_q | ~req1);
    assign w_grant1   = req1 & ~w_grant0;
    assign w_bit_end  = (baud_cnt_q == C_BAUD_LAST);
    assign w_next_bit = bit_cnt_q + 3'd1;

    always_comb begin
        w_cur_byte = 8'h00;
        case (byte_cnt_q)
            2'd0:    w_cur_byte = word_q[31:24];
            2'd1:    w_cur_byte = word_q[23:16];
            2'd2:    w_cur_byte = word_q[15:8];
            default: w_cur_byte = word_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        prio_d     = prio_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (w_grant0 || w_grant1) begin
                    word_d     = w_grant0 ? data0 : data1;
                    ack0_d     = w_grant0;
                    ack1_d     = w_grant1;
                    prio_d     = w_grant0;
                    state_d    = ST_START;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                    baud_cnt_d = 16'd0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 2'd0;
                end
            end

            ST_START: begin
                if (w_bit_end) begin
                    baud_cnt_d = 16'd0;
                    bit_cnt_d  = 3'd0;
                    state_d    = ST_DATA;
                    txd_d      = w_cur_byte[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    baud_cnt_d = 16'd0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_cnt_d = w_next_bit;
                        txd_d     = w_cur_byte[w_next_bit];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            ST_STOP: begin
                if (w_bit_end) begin
                    baud_cnt_d = 16'd0;
                    if (byte_cnt_q == 2'd3) begin
                        state_d    = ST_IDLE;
                        byte_cnt_d = 2'd0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        txd_d      = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        state_d    = ST_START;
                        txd_d      = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            prio_q     <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            prio_q     <= prio_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done_q     <= done_d;
        end
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign TxD  = txd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire
